exe_stage: RTL

Execute stage of the five-stage LoongArch pipeline, located between the decode stage and the memory stage. It registers one decoded instruction per handshake and computes its ALU result. It issues the data-SRAM request for loads and stores, and forwards the result to the memory stage. It also returns destination and result information to decode so decode can resolve hazards and bypass operands.

---
 rtl/exe_stage.sv | 93 +++++++++
 1 files changed

// File: rtl/exe_stage.sv
// Execute stage: registers one decoded instruction per handshake, computes its ALU
// result, issues the data-SRAM request and feeds results to memory and decode.
module exe_stage #(
  parameter int DS_TO_ES_BUS_WD = 151,
  parameter int ES_TO_MS_BUS_WD = 71,
  parameter int ES_TO_DS_BUS_WD = 39
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [ES_TO_DS_BUS_WD-1:0] es_to_ds_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  logic                       es_valid_r;
  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus_r;

  logic [11:0] alu_op_s;
  logic        res_from_mem_s, src1_is_pc_s, src2_is_imm_s, gr_we_s, mem_we_s, no_dest_s;
  logic [4:0]  dest_s;
  logic [31:0] imm_s, rj_value_s, rkd_value_s, pc_s;
  logic        es_ready_go_s, fire_s, es_no_dest_s, es_res_from_mem_s;
  logic [31:0] src1_s, src2_s, alu_result_s;
  logic [4:0]  shamt_s;

  assign {alu_op_s, res_from_mem_s, src1_is_pc_s, src2_is_imm_s, gr_we_s, mem_we_s,
          no_dest_s, dest_s, imm_s, rj_value_s, rkd_value_s, pc_s} = ds_to_es_bus_r;

  assign es_ready_go_s  = 1'b1;
  assign es_allowin     = !es_valid_r || (es_ready_go_s && ms_allowin);
  assign es_to_ms_valid = es_valid_r && es_ready_go_s;

  // Stage valid bit: a bubble is loaded whenever decode has nothing to offer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_valid_r <= 1'b0;
    end else if (es_allowin) begin
      es_valid_r <= ds_to_es_valid;
    end
  end

  // Instruction register: captured only on a real handshake, held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ds_to_es_bus_r <= {DS_TO_ES_BUS_WD{1'b0}};
    end else if (es_allowin && ds_to_es_valid) begin
      ds_to_es_bus_r <= ds_to_es_bus;
    end
  end

  assign src1_s  = src1_is_pc_s  ? pc_s  : rj_value_s;
  assign src2_s  = src2_is_imm_s ? imm_s : rkd_value_s;
  assign shamt_s = src2_s[4:0];

  // ALU: OR of every selected operation, so a zero op vector yields zero.
  always_comb begin
    alu_result_s = 32'h0000_0000;
    alu_result_s = alu_result_s | ({32{alu_op_s[0]}}  & (src1_s + src2_s));
    alu_result_s = alu_result_s | ({32{alu_op_s[1]}}  & (src1_s - src2_s));
    alu_result_s = alu_result_s | ({32{alu_op_s[2]}}  & {31'd0, ($signed(src1_s) < $signed(src2_s))});
    alu_result_s = alu_result_s | ({32{alu_op_s[3]}}  & {31'd0, (src1_s < src2_s)});
    alu_result_s = alu_result_s | ({32{alu_op_s[4]}}  & (src1_s & src2_s));
    alu_result_s = alu_result_s | ({32{alu_op_s[5]}}  & ~(src1_s | src2_s));
    alu_result_s = alu_result_s | ({32{alu_op_s[6]}}  & (src1_s | src2_s));
    alu_result_s = alu_result_s | ({32{alu_op_s[7]}}  & (src1_s ^ src2_s));
    alu_result_s = alu_result_s | ({32{alu_op_s[8]}}  & (src1_s << shamt_s));
    alu_result_s = alu_result_s | ({32{alu_op_s[9]}}  & (src1_s >> shamt_s));
    alu_result_s = alu_result_s | ({32{alu_op_s[10]}} & $unsigned($signed(src1_s) >>> shamt_s));
    alu_result_s = alu_result_s | ({32{alu_op_s[11]}} & src2_s);
  end

  // The request is tied to the handshake into memory so a stall never repeats it.
  assign fire_s          = es_valid_r && ms_allowin;
  assign data_sram_en    = fire_s && (res_from_mem_s || mem_we_s);
  assign data_sram_we    = (fire_s && mem_we_s) ? 4'hf : 4'h0;
  assign data_sram_addr  = alu_result_s;
  assign data_sram_wdata = rkd_value_s;

  assign es_to_ms_bus = {res_from_mem_s, gr_we_s, dest_s, alu_result_s, pc_s};

  assign es_no_dest_s      = !es_valid_r || !gr_we_s || no_dest_s || (dest_s == 5'd0);
  assign es_res_from_mem_s = es_valid_r && res_from_mem_s;
  assign es_to_ds_bus      = {es_res_from_mem_s, es_no_dest_s, dest_s, alu_result_s};

endmodule
